// File: rtl/kernel_launch_queue.sv
// rtl/kernel_launch_queue.sv - launch descriptor FIFO and single-kernel issue/retire sequencer
module kernel_launch_queue #(
    parameter int          DEPTH          = 4,
    parameter int          KID_W          = 4,
    parameter int          CYC_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   launch_valid,
    output logic                   launch_ready,
    input  logic [7:0]             launch_thread_count,
    input  logic [KID_W-1:0]       launch_kernel_id,
    output logic                   dispatch_start,
    output logic [7:0]             dispatch_thread_count,
    input  logic                   dispatch_done,
    output logic                   cmpl_valid,
    input  logic                   cmpl_ready,
    output logic [KID_W-1:0]       cmpl_kernel_id,
    output logic [CYC_W-1:0]       cmpl_cycles,
    output logic                   cmpl_error,
    output logic [$clog2(DEPTH):0] queue_count,
    output logic                   busy,
    output logic [15:0]            kernels_done
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_MASK, S_RUN, S_CMPL} state_t;

    state_t           state_q, state_d;
    logic [7:0]       tc_mem  [DEPTH];
    logic [KID_W-1:0] kid_mem [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic [7:0]       tc_q;
    logic [KID_W-1:0] kid_q;
    logic [CYC_W-1:0] cyc_q, cyc_inc;
    logic             err_q, mask_q;
    logic [15:0]      done_cnt_q;
    logic             push, pop, timeout_hit;

    // Ready looks only at the registered count, so a full FIFO never accepts in a pop cycle.
    assign launch_ready = !reset && (count_q < (AW+1)'(DEPTH));
    assign push         = launch_valid && launch_ready;
    assign pop          = (state_q == S_IDLE) && (count_q != '0);
    assign cyc_inc      = (&cyc_q) ? cyc_q : cyc_q + 1'b1;
    assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (32'(cyc_inc) >= TIMEOUT_CYCLES);

    always_comb begin
        state_d        = state_q;
        dispatch_start = 1'b0;
        cmpl_valid     = 1'b0;
        case (state_q)
            S_IDLE:  if (count_q != '0) state_d = (tc_mem[rptr_q] == 8'd0) ? S_CMPL : S_START;
            S_START: begin
                dispatch_start = 1'b1;
                state_d        = S_MASK;
            end
            // Done may still be high from the previous kernel, so it is not looked at here.
            S_MASK:  if (mask_q) state_d = S_RUN;
            S_RUN:   if (dispatch_done || timeout_hit) state_d = S_CMPL;
            S_CMPL: begin
                cmpl_valid = 1'b1;
                if (cmpl_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tc_mem[wptr_q]  <= launch_thread_count;
            kid_mem[wptr_q] <= launch_kernel_id;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            tc_q       <= '0;
            kid_q      <= '0;
            cyc_q      <= '0;
            err_q      <= 1'b0;
            mask_q     <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (push) wptr_q <= wptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            case (state_q)
                S_IDLE: if (pop) begin
                    rptr_q <= rptr_q + 1'b1;
                    tc_q   <= tc_mem[rptr_q];
                    kid_q  <= kid_mem[rptr_q];
                    cyc_q  <= '0;
                    err_q  <= 1'b0;
                end
                S_START: begin
                    cyc_q  <= CYC_W'(1);
                    mask_q <= 1'b0;
                end
                S_MASK: begin
                    cyc_q  <= cyc_inc;
                    mask_q <= ~mask_q;
                end
                // The detection cycle itself is counted; done wins over a same-cycle timeout.
                S_RUN: begin
                    cyc_q <= cyc_inc;
                    if (!dispatch_done && timeout_hit) err_q <= 1'b1;
                end
                S_CMPL: if (cmpl_ready) done_cnt_q <= done_cnt_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign dispatch_thread_count = tc_q;
    assign cmpl_kernel_id        = kid_q;
    assign cmpl_cycles           = cyc_q;
    assign cmpl_error            = err_q;
    assign queue_count           = count_q;
    assign busy                  = (state_q != S_IDLE) || (count_q != '0);
    assign kernels_done          = done_cnt_q;
endmodule

// File: tb/tb_kernel_launch_queue.sv
// tb/tb_kernel_launch_queue.sv - directed self-checking bench for kernel_launch_queue
module tb_kernel_launch_queue;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        launch_valid = 1'b0;
    logic        launch_ready;
    logic [7:0]  launch_thread_count = '0;
    logic [3:0]  launch_kernel_id = '0;
    logic        dispatch_start;
    logic [7:0]  dispatch_thread_count;
    logic        dispatch_done = 1'b0;
    logic        cmpl_valid;
    logic        cmpl_ready = 1'b1;
    logic [3:0]  cmpl_kernel_id;
    logic [15:0] cmpl_cycles;
    logic        cmpl_error;
    logic [2:0]  queue_count;
    logic        busy;
    logic [15:0] kernels_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    kernel_launch_queue #(
        .DEPTH(4), .KID_W(4), .CYC_W(16), .TIMEOUT_CYCLES(20)
    ) dut (
        .clk(clk), .reset(reset),
        .launch_valid(launch_valid), .launch_ready(launch_ready),
        .launch_thread_count(launch_thread_count), .launch_kernel_id(launch_kernel_id),
        .dispatch_start(dispatch_start), .dispatch_thread_count(dispatch_thread_count),
        .dispatch_done(dispatch_done),
        .cmpl_valid(cmpl_valid), .cmpl_ready(cmpl_ready),
        .cmpl_kernel_id(cmpl_kernel_id), .cmpl_cycles(cmpl_cycles), .cmpl_error(cmpl_error),
        .queue_count(queue_count), .busy(busy), .kernels_done(kernels_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Dispatcher model: done drops 3 cycles after start and rises done_delay cycles after start.
    int tmr = 0;
    bit running = 0;
    bit done_en = 1;
    int done_delay = 6;
    always @(negedge clk) begin
        if (reset) running = 0;
        else if (dispatch_start) begin
            tmr = 0;
            running = 1;
        end else if (running) begin
            tmr++;
            if (tmr == 3) dispatch_done = 1'b0;
            if (done_en && tmr == done_delay) begin
                dispatch_done = 1'b1;
                running = 0;
            end
        end
    end

    int start_cyc[$];
    int start_tc[$];
    int hs_cyc[$];
    int cq_kid[$];
    int cq_cyc[$];
    int cq_err[$];
    always @(negedge clk) begin
        #1;
        if (!reset) begin
            if (dispatch_start) begin
                start_cyc.push_back(cyc);
                start_tc.push_back(int'(dispatch_thread_count));
            end
            if (cmpl_valid && cmpl_ready) begin
                hs_cyc.push_back(cyc);
                cq_kid.push_back(int'(cmpl_kernel_id));
                cq_cyc.push_back(int'(cmpl_cycles));
                cq_err.push_back(int'(cmpl_error));
            end
        end
    end

    task automatic push(input logic [7:0] tc, input logic [3:0] id, output int acc);
        int g;
        launch_valid = 1'b1;
        launch_thread_count = tc;
        launch_kernel_id = id;
        g = 0;
        while (!launch_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        n_checks++;
        if (launch_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL push_accept id=%0d: launch_ready=%b required 1", id, launch_ready);
        end
        acc = cyc;
        @(negedge clk);
        launch_valid = 1'b0;
    endtask

    task automatic wait_cmpls(input int n);
        int g;
        g = 0;
        while (cq_kid.size() < n && g < 300) begin
            @(negedge clk);
            #2;
            g++;
        end
        n_checks++;
        if (cq_kid.size() < n) begin
            n_fail++;
            $display("FAIL wait_cmpl: completions=%0d required %0d", cq_kid.size(), n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({launch_ready, dispatch_start, cmpl_valid, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: ready/start/valid/busy=%b required 0000",
                     {launch_ready, dispatch_start, cmpl_valid, busy});
        end
        n_checks++;
        if ({queue_count, kernels_done, dispatch_thread_count, cmpl_cycles, cmpl_kernel_id, cmpl_error} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: qc=%0d kd=%0d dtc=%0d cyc=%0d kid=%0d err=%b required all 0",
                     queue_count, kernels_done, dispatch_thread_count, cmpl_cycles, cmpl_kernel_id, cmpl_error);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (launch_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b required 1", launch_ready);
        end
    endtask

    task automatic test_single();
        int acc, g;
        cmpl_ready = 1'b0;
        done_delay = 6;
        @(negedge clk);
        push(8'd10, 4'd3, acc);
        g = 0;
        while (!cmpl_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        n_checks++;
        if (start_cyc.size() != 1 || start_cyc[0] - acc != 2) begin
            n_fail++;
            $display("FAIL single_start: starts=%0d latency=%0d required 1 start, latency 2",
                     start_cyc.size(), (start_cyc.size() > 0) ? start_cyc[0] - acc : -1);
        end
        n_checks++;
        if (start_tc.size() < 1 || start_tc[0] != 10) begin
            n_fail++;
            $display("FAIL single_tc: dispatch_thread_count at start=%0d required 10",
                     (start_tc.size() > 0) ? start_tc[0] : -1);
        end
        n_checks++;
        if ({cmpl_valid, cmpl_kernel_id, cmpl_cycles, cmpl_error} !== {1'b1, 4'd3, 16'd7, 1'b0}) begin
            n_fail++;
            $display("FAIL single_cmpl: valid=%b id=%0d cycles=%0d err=%b required 1 3 7 0",
                     cmpl_valid, cmpl_kernel_id, cmpl_cycles, cmpl_error);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({cmpl_valid, cmpl_kernel_id, cmpl_cycles, busy} !== {1'b1, 4'd3, 16'd7, 1'b1}) begin
            n_fail++;
            $display("FAIL single_hold: valid=%b id=%0d cycles=%0d busy=%b required 1 3 7 1",
                     cmpl_valid, cmpl_kernel_id, cmpl_cycles, busy);
        end
        cmpl_ready = 1'b1;
        wait_cmpls(1);
        @(negedge clk);
        n_checks++;
        if ({kernels_done, busy, cmpl_valid, dispatch_thread_count} !== {16'd1, 1'b0, 1'b0, 8'd10}) begin
            n_fail++;
            $display("FAIL single_retire: kd=%0d busy=%b valid=%b dtc=%0d required 1 0 0 10",
                     kernels_done, busy, cmpl_valid, dispatch_thread_count);
        end
    endtask

    task automatic test_stale_done();
        int acc;
        done_delay = 5;
        push(8'd20, 4'd5, acc);
        wait_cmpls(2);
        n_checks++;
        if (cq_kid[1] != 5 || cq_cyc[1] != 6 || cq_err[1] != 0) begin
            n_fail++;
            $display("FAIL stale_done: id=%0d cycles=%0d err=%0d required 5 6 0",
                     cq_kid[1], cq_cyc[1], cq_err[1]);
        end
        @(negedge clk);
        n_checks++;
        if (kernels_done !== 16'd2) begin
            n_fail++;
            $display("FAIL stale_count: kernels_done=%0d required 2", kernels_done);
        end
    endtask

    task automatic test_back_to_back();
        int acc[6];
        int sb, cb;
        done_delay = 6;
        sb = start_cyc.size();
        cb = cq_kid.size();
        @(negedge clk);
        for (int i = 0; i < 5; i++) push(8'(i + 1), 4'(i + 1), acc[i]);
        n_checks++;
        if (queue_count !== 3'd4 || launch_ready !== 1'b0 || acc[4] - acc[0] != 4) begin
            n_fail++;
            $display("FAIL b2b_full: qc=%0d ready=%b push_span=%0d required 4 0 4",
                     queue_count, launch_ready, acc[4] - acc[0]);
        end
        push(8'd6, 4'd6, acc[5]);
        wait_cmpls(cb + 6);
        n_checks++;
        if (start_cyc.size() < sb + 2 || acc[5] != start_cyc[sb + 1]) begin
            n_fail++;
            $display("FAIL b2b_full_pop: accept_cyc=%0d required %0d", acc[5],
                     (start_cyc.size() >= sb + 2) ? start_cyc[sb + 1] : -1);
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (cq_kid[cb + i] != i + 1 || cq_cyc[cb + i] != 7 || cq_err[cb + i] != 0 ||
                start_tc[sb + i] != i + 1) begin
                n_fail++;
                $display("FAIL b2b_cmpl[%0d]: id=%0d cycles=%0d err=%0d tc=%0d required %0d 7 0 %0d",
                         i, cq_kid[cb + i], cq_cyc[cb + i], cq_err[cb + i], start_tc[sb + i], i + 1, i + 1);
            end
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (start_cyc[sb + i + 1] - hs_cyc[cb + i] < 2) begin
                n_fail++;
                $display("FAIL b2b_gap[%0d]: cmpl_to_start=%0d required >=2",
                         i, start_cyc[sb + i + 1] - hs_cyc[cb + i]);
            end
        end
        @(negedge clk);
        n_checks++;
        if (kernels_done !== 16'd8) begin
            n_fail++;
            $display("FAIL b2b_count: kernels_done=%0d required 8", kernels_done);
        end
    endtask

    task automatic test_tc_zero();
        int acc, sb, cb;
        sb = start_cyc.size();
        cb = cq_kid.size();
        @(negedge clk);
        push(8'd0, 4'd7, acc);
        wait_cmpls(cb + 1);
        n_checks++;
        if (cq_kid[cb] != 7 || cq_cyc[cb] != 0 || cq_err[cb] != 0) begin
            n_fail++;
            $display("FAIL tc0_cmpl: id=%0d cycles=%0d err=%0d required 7 0 0",
                     cq_kid[cb], cq_cyc[cb], cq_err[cb]);
        end
        @(negedge clk);
        #2;
        n_checks++;
        if (start_cyc.size() != sb || dispatch_thread_count !== 8'd0 || kernels_done !== 16'd9) begin
            n_fail++;
            $display("FAIL tc0_nostart: new_starts=%0d dtc=%0d kd=%0d required 0 0 9",
                     start_cyc.size() - sb, dispatch_thread_count, kernels_done);
        end
    endtask

    task automatic test_timeout();
        int acc, cb;
        done_en = 0;
        cb = cq_kid.size();
        @(negedge clk);
        push(8'd5, 4'd9, acc);
        wait_cmpls(cb + 1);
        n_checks++;
        if (cq_kid[cb] != 9 || cq_cyc[cb] != 20 || cq_err[cb] != 1) begin
            n_fail++;
            $display("FAIL timeout_cmpl: id=%0d cycles=%0d err=%0d required 9 20 1",
                     cq_kid[cb], cq_cyc[cb], cq_err[cb]);
        end
        done_en = 1;
    endtask

    task automatic test_reset_mid_run();
        int acc, sb, cb;
        bit saw_start;
        done_en = 0;
        @(negedge clk);
        push(8'd1, 4'd1, acc);
        push(8'd2, 4'd2, acc);
        push(8'd3, 4'd3, acc);
        repeat (3) @(negedge clk);
        n_checks++;
        if (queue_count !== 3'd2 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: qc=%0d busy=%b required 2 1", queue_count, busy);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (launch_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_ready: launch_ready=%b required 0", launch_ready);
        end
        @(negedge clk);
        n_checks++;
        if ({queue_count, cmpl_valid, busy, dispatch_start, kernels_done} !== '0) begin
            n_fail++;
            $display("FAIL rst_flush: qc=%0d valid=%b busy=%b start=%b kd=%0d required all 0",
                     queue_count, cmpl_valid, busy, dispatch_start, kernels_done);
        end
        reset = 1'b0;
        sb = start_cyc.size();
        cb = cq_kid.size();
        saw_start = 0;
        repeat (40) begin
            @(negedge clk);
            if (dispatch_start || cmpl_valid) saw_start = 1;
        end
        #2;
        n_checks++;
        if (saw_start || start_cyc.size() != sb || cq_kid.size() != cb || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_quiet: activity=%b starts=%0d cmpls=%0d busy=%b required 0 0 0 0",
                     saw_start, start_cyc.size() - sb, cq_kid.size() - cb, busy);
        end
        done_en = 1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stale_done();
        test_back_to_back();
        test_tc_zero();
        test_timeout();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1);
    end
endmodule
